sccb_slave_regfile: RTL and testbench
=====================================

Name: sccb_slave_regfile

Overview:
- SCCB/I2C target that answers the OV5640-style 3-phase protocol: device address, 16-bit register address, 8-bit data.
- Acts as the responder to the camera-config master. Used as a camera stand-in on the bench and as a board-level control port into FPGA registers.
- Holds a small register file that the master can read back.
- Every accepted write is also forwarded to fabric as a one-cycle strobe.

Parameters:
- DEV_ADDR, 7'h3C, 7-bit target address. The write byte is 8'h78 and the read byte is 8'h79.
- ADDR_BITS, 6, number of low register-address bits that index the internal file. Depth = 2^ADDR_BITS.
- MIN_HALF, 4, minimum clk_25M cycles that SCL must stay high or low to be recognised.

Ports:
- clk_25M  input  1  system clock.
- camera_rstn  input  1  synchronous active-low reset.
- i2c_sclk  input  1  bus clock from master.
- i2c_sdat  inout  1  bus data. This block drives only 1'b0 or 1'bz.
- wr_strobe  output  1  one-cycle pulse per accepted data byte.
- wr_addr  output  16  register address of the pulsed write.
- wr_data  output  8  data of the pulsed write.
- busy  output  1  high from a matched address byte until STOP.

Behaviour:
- Reset (camera_rstn low at a clk_25M edge):
  - SDA is released (z).
  - wr_strobe=0, wr_addr=0, wr_data=0, busy=0, FSM=IDLE, address pointer=0.
  - All file entries are cleared to 8'h00.
  - Reset asserted mid-transfer releases SDA on the same edge.
- Input conditioning: SCL and SDA each pass through a 2-flop synchroniser. All edges are detected on the synchronised copies.
- Bus events:
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
- Bit timing:
  - Bits are sampled on SCL rising, MSB first.
  - The slave changes SDA only on SCL falling, in the first clk_25M cycle after the synchronised edge.
- FSM states: IDLE, DEV, ACK_DEV, RA_HI, ACK_HI, RA_LO, ACK_LO, WDATA, ACK_W, RDATA, MACK.
- Transitions:
  - START from any state → DEV, bit counter=0. This covers repeated start.
  - STOP from any state → IDLE, SDA released, busy=0.
  - DEV, after 8 bits:
    - Address match with R/W=0 → ACK_DEV (write).
    - Address match with R/W=1 → ACK_DEV (read).
    - Mismatch → IDLE with no ACK (NACK); nothing is driven until the next START.
  - ACK_DEV (write) → RA_HI → ACK_HI → RA_LO → ACK_LO → WDATA → ACK_W → WDATA, repeating.
  - ACK_DEV (read) → RDATA → MACK. On master ACK (SDA low at rising edge) → RDATA; on master NACK → IDLE, waiting for STOP/START.
- ACK phases:
  - The slave pulls SDA low from the SCL falling edge after bit 8 until the next SCL falling edge.
  - Read data bytes are not ACKed by the slave.
- Pointer:
  - RA_HI loads pointer[15:8]; RA_LO loads pointer[7:0].
  - Each written or read data byte increments the pointer after use. Wrap is 16'hFFFF → 16'h0000.
  - The file index is pointer[ADDR_BITS-1:0] (aliasing is intended).
- Write path:
  - At entry to ACK_W, the file entry is updated and wr_addr/wr_data are loaded with the pre-increment pointer and the byte.
  - wr_strobe=1 for exactly that one clk_25M cycle.
  - A STOP or START before bit 8 of a byte discards the partial byte: no strobe, no file change.
- Read path:
  - The byte is fetched from the file at entry to RDATA.
  - Bit 7 is driven on the first SCL falling edge in RDATA. A 1 bit is driven as z, a 0 bit as low.
  - Reading right after the device byte returns data at the pointer left by the last transaction.
- Glitch rejection: an SCL level shorter than MIN_HALF cycles is ignored; the counter is restarted on each change.
- busy is set at the ACK_DEV entry for a matched address and cleared on STOP or reset.

Optional Feature:
- Macro: SCCB_GLITCH_FILTER_EN.
- Defined: each synchronised line also passes a 3-sample majority filter. This adds 2 clk_25M cycles to all event-detect and drive latencies and rejects single-cycle spikes on SDA/SCL.
- Undefined: 2-flop synchroniser only, with the latency stated above.

Test Plan:
- Write 78,31,03,11 then STOP → 4 slave ACKs; one wr_strobe with wr_addr=16'h3103, wr_data=8'h11; entry 6'h03=8'h11; busy low after STOP.
- Burst 78,30,08,82,42,FF → wr_strobe ×3 at addresses 3008/3009/300A with data 82/42/FF.
- Write 78,30,08, repeated start, 79, read 3 bytes (ACK,ACK,NACK) after the previous burst → returns 82,42,FF; SDA released after the NACK.
- Address byte 8'h42 → SDA never driven low, no wr_strobe, busy stays 0 until the next START.
- Pointer FFFF with 2 data bytes AA,BB → wr_addr FFFF then 0000.
- Abort cases:
  - STOP after 5 bits of a data byte → no strobe, FSM returns to IDLE.
  - camera_rstn low during an ACK → SDA z on the next edge, file cleared.

Source files
------------

// File: rtl/sccb_slave_regfile.sv
//==============================================================================
// Module   : sccb_slave_regfile
// Brief    : SCCB/I2C target (device byte, 16-bit register address, data bytes)
//            backed by a small register file; accepted writes pulse to fabric.
//            Define SCCB_GLITCH_FILTER_EN to add a 3-sample majority filter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sccb_slave_regfile #(
    parameter logic [6:0] DEV_ADDR  = 7'h3C,
    parameter int         ADDR_BITS = 6,
    parameter int         MIN_HALF  = 4
) (
    input  logic        clk_25M,
    input  logic        camera_rstn,
    input  logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic        wr_strobe,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    localparam int               DEPTH    = 1 << ADDR_BITS;
    localparam int               CNT_W    = $clog2(MIN_HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_HALF - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_DEV     = 4'd1,
        S_ACK_DEV = 4'd2,
        S_RA_HI   = 4'd3,
        S_ACK_HI  = 4'd4,
        S_RA_LO   = 4'd5,
        S_ACK_LO  = 4'd6,
        S_WDATA   = 4'd7,
        S_ACK_W   = 4'd8,
        S_RDATA   = 4'd9,
        S_MACK    = 4'd10
    } state_t;

    //--------------------------------------------------------------------------
    // Input conditioning
    //--------------------------------------------------------------------------
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_line;
    logic       sda_line;

    always_ff @(posedge clk_25M) begin
        if (!camera_rstn) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i2c_sclk};
            sda_sync_q <= {sda_sync_q[0], i2c_sdat};
        end
    end

`ifdef SCCB_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q;
    logic [2:0] sda_hist_q;

    always_ff @(posedge clk_25M) begin
        if (!camera_rstn) begin
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
        end else begin
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
        end
    end

    assign scl_line = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                      (scl_hist_q[1] & scl_hist_q[2]);
    assign sda_line = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                      (sda_hist_q[1] & sda_hist_q[2]);
`else
    assign scl_line = scl_sync_q[1];
    assign sda_line = sda_sync_q[1];
`endif

    // SCL is only accepted at a new level after holding it MIN_HALF cycles.
    logic [CNT_W-1:0] scl_cnt_q;
    logic             scl_filt_q;
    logic             scl_prev_q;
    logic             sda_prev_q;

    always_ff @(posedge clk_25M) begin
        if (!camera_rstn) begin
            scl_cnt_q  <= '0;
            scl_filt_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_filt_q;
            sda_prev_q <= sda_line;
            if (scl_line == scl_filt_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == CNT_LAST) begin
                scl_filt_q <= scl_line;
                scl_cnt_q  <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 1'b1;
            end
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic bus_start;
    logic bus_stop;

    assign scl_rise  = scl_filt_q & ~scl_prev_q;
    assign scl_fall  = ~scl_filt_q & scl_prev_q;
    assign bus_start = scl_filt_q & scl_prev_q & sda_prev_q & ~sda_line;
    assign bus_stop  = scl_filt_q & scl_prev_q & ~sda_prev_q & sda_line;

    //--------------------------------------------------------------------------
    // Protocol FSM and datapath
    //--------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        rw_q, rw_d;
    logic        mack_q, mack_d;
    logic [15:0] ptr_q, ptr_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        mem_we;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  byte_in;
    logic [7:0]  rd_byte;

    assign byte_in = {shift_q[6:0], sda_line};
    assign rd_byte = mem_q[ptr_q[ADDR_BITS-1:0]];

    always_ff @(posedge clk_25M) begin
        if (!camera_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_we      = 1'b0;

        if (bus_stop) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (bus_start) begin
            state_d  = S_DEV;
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                end

                S_DEV: begin
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_d = S_ACK_DEV;
                                rw_d    = byte_in[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end

                S_RA_HI, S_RA_LO, S_WDATA: begin
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            if (state_q == S_RA_HI) begin
                                ptr_d[15:8] = byte_in;
                                state_d     = S_ACK_HI;
                            end else if (state_q == S_RA_LO) begin
                                ptr_d[7:0] = byte_in;
                                state_d    = S_ACK_LO;
                            end else begin
                                mem_we      = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                                wr_data_d   = byte_in;
                                ptr_d       = ptr_q + 16'd1;
                                state_d     = S_ACK_W;
                            end
                        end
                    end
                end

                // First falling edge asserts the ACK, the next one releases it.
                S_ACK_DEV, S_ACK_HI, S_ACK_LO, S_ACK_W: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            bitcnt_d = 4'd0;
                            case (state_q)
                                S_ACK_DEV: begin
                                    if (rw_q) begin
                                        state_d  = S_RDATA;
                                        shift_d  = {rd_byte[6:0], 1'b0};
                                        sda_oe_d = ~rd_byte[7];
                                    end else begin
                                        state_d = S_RA_HI;
                                    end
                                end
                                S_ACK_HI: state_d = S_RA_LO;
                                default:  state_d = S_WDATA;
                            endcase
                        end
                    end
                end

                S_RDATA: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + 16'd1;
                            mack_d   = 1'b0;
                            state_d  = S_MACK;
                        end else begin
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                        end
                    end
                end

                S_MACK: begin
                    if (scl_rise) begin
                        if (!sda_line) begin
                            mack_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (scl_fall && mack_q) begin
                        mack_d   = 1'b0;
                        bitcnt_d = 4'd0;
                        state_d  = S_RDATA;
                        shift_d  = {rd_byte[6:0], 1'b0};
                        sda_oe_d = ~rd_byte[7];
                    end
                end

                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_25M) begin
        if (!camera_rstn) begin
            bitcnt_q    <= 4'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            mack_q      <= 1'b0;
            ptr_q       <= 16'h0000;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 16'h0000;
            wr_data_q   <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            if (mem_we) begin
                mem_q[ptr_q[ADDR_BITS-1:0]] <= byte_in;
            end
        end
    end

    assign i2c_sdat  = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sccb_slave_regfile.sv
//==============================================================================
// Module   : tb_sccb_slave_regfile
// Brief    : Bus-master bench for sccb_slave_regfile against a transaction-level
//            register-file model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sccb_slave_regfile;

    localparam int H = 32;
    localparam int Q = 14;

    logic        clk = 1'b0;
    logic        rstn;
    logic        scl;
    logic        m_oe;
    wire         sda_bus;
    logic        wr_strobe;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    always #20 clk = ~clk;

    pullup (sda_bus);
    assign sda_bus = m_oe ? 1'b0 : 1'bz;

    sccb_slave_regfile #(
        .DEV_ADDR  (7'h3C),
        .ADDR_BITS (6),
        .MIN_HALF  (4)
    ) dut (
        .clk_25M     (clk),
        .camera_rstn (rstn),
        .i2c_sclk    (scl),
        .i2c_sdat    (sda_bus),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    int n_chk   = 0;
    int n_fail  = 0;
    int dut_low = 0;
    int rd_idx  = 0;
    logic [23:0] obs_q [$];
    logic [23:0] exp_q [$];
    logic [7:0]  txb   [$];
    logic [7:0]  m_mem [64];
    logic [15:0] m_ptr;

    always @(negedge clk) begin
        if (wr_strobe) obs_q.push_back({wr_addr, wr_data});
        if (!m_oe && sda_bus === 1'b0) dut_low <= dut_low + 1;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycles used %0d required below %0d", 95000, 95000);
        $fatal(1, "cycle budget exhausted");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: byte-addressed file with an auto-incrementing pointer.
    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
        m_ptr = 16'h0000;
    endfunction

    function automatic void mwr(input logic [7:0] b);
        exp_q.push_back({m_ptr, b});
        m_mem[m_ptr[5:0]] = b;
        m_ptr = m_ptr + 16'd1;
    endfunction

    function automatic logic [7:0] mrd();
        logic [7:0] v;
        v = m_mem[m_ptr[5:0]];
        m_ptr = m_ptr + 16'd1;
        return v;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        wait_clk(Q);
        m_oe = ~b;
        wait_clk(H - Q);
        scl = 1'b1;
        wait_clk(H / 2);
        s = sda_bus;
        wait_clk(H / 2);
        scl = 1'b0;
    endtask

    task automatic i2c_start();
        if (scl == 1'b0) begin
            wait_clk(Q);
            m_oe = 1'b0;
            wait_clk(H - Q);
            scl = 1'b1;
            wait_clk(H / 2);
        end
        m_oe = 1'b1;
        wait_clk(H / 2);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q);
        m_oe = 1'b1;
        wait_clk(H - Q);
        scl = 1'b1;
        wait_clk(H / 2);
        m_oe = 1'b0;
        wait_clk(H);
    endtask

    task automatic wb(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic rb(input logic mack, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            v[i] = s;
        end
        bit_cycle(~mack, s);
    endtask

    task automatic write_txn(input logic [15:0] a);
        logic ack;
        i2c_start();
        wb(8'h78, ack);
        chk("dev_w_ack", ack, 1);
        chk("busy_set", busy, 1);
        wb(a[15:8], ack);
        chk("ra_hi_ack", ack, 1);
        wb(a[7:0], ack);
        chk("ra_lo_ack", ack, 1);
        m_ptr = a;
        foreach (txb[i]) begin
            wb(txb[i], ack);
            chk("data_ack", ack, 1);
            mwr(txb[i]);
        end
        i2c_stop();
        chk("busy_clr", busy, 0);
    endtask

    task automatic read_txn(input int n, input bit set_ptr, input logic [15:0] a);
        logic       ack;
        logic [7:0] v;
        logic [7:0] e;
        i2c_start();
        if (set_ptr) begin
            wb(8'h78, ack);
            chk("rp_dev_ack", ack, 1);
            wb(a[15:8], ack);
            chk("rp_hi_ack", ack, 1);
            wb(a[7:0], ack);
            chk("rp_lo_ack", ack, 1);
            m_ptr = a;
            i2c_start();
        end
        wb(8'h79, ack);
        chk("dev_r_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            rb(i != n - 1, v);
            e = mrd();
            chk("rd_data", v, e);
        end
        wait_clk(Q);
        chk("sda_rel_nack", sda_bus, 1);
        i2c_stop();
    endtask

    task automatic check_strobes(input string tag);
        int got_n;
        got_n = obs_q.size() - rd_idx;
        chk({tag, "_cnt"}, got_n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
            chk(tag, obs_q[rd_idx + i], exp_q[i]);
        end
        rd_idx = obs_q.size();
        exp_q.delete();
    endtask

    initial begin
        logic        ack;
        logic        s;
        int          base;
        int          n;
        logic [15:0] a;

        rstn = 1'b0;
        scl  = 1'b1;
        m_oe = 1'b0;
        model_reset();
        wait_clk(4);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sda", sda_bus, 1);
        rstn = 1'b1;
        wait_clk(10);

        // Single write
        txb = '{8'h11};
        write_txn(16'h3103);
        check_strobes("single_wr");

        // Burst write
        txb = '{8'h82, 8'h42, 8'hFF};
        write_txn(16'h3008);
        check_strobes("burst_wr");

        // Repeated-start read of the burst
        read_txn(3, 1'b1, 16'h3008);

        // Foreign address: never acknowledged or driven
        base = dut_low;
        i2c_start();
        wb(8'h42, ack);
        chk("foreign_nack", ack, 0);
        chk("foreign_busy", busy, 0);
        wb(8'h31, ack);
        chk("foreign_nack2", ack, 0);
        i2c_stop();
        chk("foreign_sda_low_cycles", dut_low - base, 0);
        check_strobes("foreign_wr");

        // Pointer wrap
        txb = '{8'hAA, 8'hBB};
        write_txn(16'hFFFF);
        check_strobes("wrap_wr");

        // Read straight after the device byte continues from the pointer
        read_txn(2, 1'b0, 16'h0000);

        // Partial data byte followed by STOP
        i2c_start();
        wb(8'h78, ack);
        chk("abort_dev_ack", ack, 1);
        wb(8'h30, ack);
        wb(8'h10, ack);
        m_ptr = 16'h3010;
        for (int i = 0; i < 5; i++) bit_cycle(1'($urandom_range(0, 1)), s);
        i2c_stop();
        chk("abort_busy", busy, 0);
        check_strobes("abort_wr");
        read_txn(1, 1'b1, 16'h3010);

        // Randomized write-then-readback
        for (int it = 0; it < 3; it++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            n = $urandom_range(1, 4);
            txb.delete();
            for (int k = 0; k < n; k++) txb.push_back(8'($urandom_range(0, 255)));
            write_txn(a);
            check_strobes("rand_wr");
            read_txn(n, 1'b1, a);
        end

        // Reset during the slave's ACK
        i2c_start();
        wb(8'h78, ack);
        wb(8'h31, ack);
        for (int i = 7; i >= 0; i--) bit_cycle(1'(8'h03 >> i), s);
        wait_clk(Q);
        chk("ack_before_rst", sda_bus, 0);
        rstn = 1'b0;
        wait_clk(1);
        chk("rst_mid_sda", sda_bus, 1);
        chk("rst_mid_busy", busy, 0);
        rstn = 1'b1;
        model_reset();
        i2c_stop();
        check_strobes("rst_mid_wr");
        read_txn(3, 1'b1, 16'h3008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
